// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in/serial-out serializer and its downstream detector bench.
// State encoding is one-hot so the detector bench can decode it directly.
package piso_serializer_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'b001,
    S_SHIFT = 3'b010,
    S_GAP   = 3'b100
  } state_t;

  localparam int   DEFAULT_WIDTH      = 8;
  localparam logic DEFAULT_IDLE_LEVEL = 1'b1;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer: valid/ready word input, one bit per clock on dout.
// Optional even-parity trailer bit is enabled by defining PISO_PARITY_EN.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int   WIDTH      = DEFAULT_WIDTH,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter int   GAP        = 0,
  parameter logic IDLE_LEVEL = DEFAULT_IDLE_LEVEL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy
);

`ifdef PISO_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  localparam int CNT_W = cnt_width(WIDTH + 1);
  localparam int GAP_W = cnt_width(GAP + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((GAP > 0) ? GAP - 1 : 0);
  localparam bit BACK_TO_BACK = (GAP == 0);

  state_t           state_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0] bit_cnt_reg;
  logic [GAP_W-1:0] gap_cnt_reg;
  logic             dout_reg;
  logic             dout_valid_reg;
  logic [WIDTH-1:0] data_ordered;
  logic             last_bit;
  logic             accept;
  logic             bit_next;
`ifdef PISO_PARITY_EN
  logic             parity_reg;
`endif

  // Reorder the word so the shifter always transmits from its top bit.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_order
      if (MSB_FIRST) begin : g_msb
        assign data_ordered[gi] = data_in[gi];
      end else begin : g_lsb
        assign data_ordered[gi] = data_in[WIDTH-1-gi];
      end
    end
  endgenerate

  assign last_bit   = (state_reg == S_SHIFT) && (bit_cnt_reg == LAST_BIT);
  assign data_ready = !rst && ((state_reg == S_IDLE) || (BACK_TO_BACK && last_bit));
  assign accept     = data_valid && data_ready;
  assign busy       = (state_reg != S_IDLE);
  assign dout       = dout_reg;
  assign dout_valid = dout_valid_reg;

  always_comb begin
    bit_next = shift_reg[WIDTH-2];
`ifdef PISO_PARITY_EN
    if (bit_cnt_reg == CNT_W'(WIDTH - 1)) begin
      bit_next = parity_reg;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      shift_reg      <= '0;
      bit_cnt_reg    <= '0;
      gap_cnt_reg    <= '0;
      dout_reg       <= IDLE_LEVEL;
      dout_valid_reg <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_reg     <= 1'b0;
`endif
    end else if (accept) begin
      // Accept is possible from IDLE, or on the final frame bit when back-to-back is allowed.
      state_reg      <= S_SHIFT;
      shift_reg      <= data_ordered;
      bit_cnt_reg    <= '0;
      dout_reg       <= data_ordered[WIDTH-1];
      dout_valid_reg <= 1'b1;
`ifdef PISO_PARITY_EN
      parity_reg     <= ^data_in;
`endif
    end else begin
      case (state_reg)
        S_IDLE: begin
          dout_reg       <= IDLE_LEVEL;
          dout_valid_reg <= 1'b0;
        end
        S_SHIFT: begin
          if (last_bit) begin
            dout_reg       <= IDLE_LEVEL;
            dout_valid_reg <= 1'b0;
            gap_cnt_reg    <= '0;
            state_reg      <= BACK_TO_BACK ? S_IDLE : S_GAP;
          end else begin
            shift_reg   <= shift_reg << 1;
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            dout_reg    <= bit_next;
          end
        end
        S_GAP: begin
          if (gap_cnt_reg == LAST_GAP) begin
            state_reg <= S_IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg      <= S_IDLE;
          dout_reg       <= IDLE_LEVEL;
          dout_valid_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: default, GAP=2 and LSB-first instances.
// Builds with or without PISO_PARITY_EN; frame expectations follow the macro.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = '0, g_data_in = '0, l_data_in = '0;
  logic       data_valid = 1'b0, g_data_valid = 1'b0, l_data_valid = 1'b0;
  logic       data_ready, dout, dout_valid, busy;
  logic       g_data_ready, g_dout, g_dout_valid, g_busy;
  logic       l_data_ready, l_dout, l_dout_valid, l_busy;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  piso_serializer u_dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .dout(dout), .dout_valid(dout_valid), .busy(busy)
  );

  piso_serializer #(.GAP(2)) u_gap (
    .clk(clk), .rst(rst), .data_in(g_data_in), .data_valid(g_data_valid),
    .data_ready(g_data_ready), .dout(g_dout), .dout_valid(g_dout_valid), .busy(g_busy)
  );

  piso_serializer #(.MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .data_in(l_data_in), .data_valid(l_data_valid),
    .data_ready(l_data_ready), .dout(l_dout), .dout_valid(l_dout_valid), .busy(l_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Checks one full frame on the default instance; stream is in transmission order, MSB = first bit.
  task automatic shift_main(input string tag, input logic [7:0] stream, input logic par);
    logic [7:0] s;
    s = stream;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_bit%0d", tag, i), dout, s[7-i]);
      check($sformatf("%s_vld%0d", tag, i), dout_valid, 1'b1);
      check($sformatf("%s_busy%0d", tag, i), busy, 1'b1);
      check($sformatf("%s_rdy%0d", tag, i), data_ready, (i == FRAME - 1));
      tick();
    end
`ifdef PISO_PARITY_EN
    check($sformatf("%s_par", tag), dout, par);
    check($sformatf("%s_par_vld", tag), dout_valid, 1'b1);
    check($sformatf("%s_par_rdy", tag), data_ready, 1'b1);
    tick();
`else
    $display("%s frame done (no parity bit, par=%0b unused)", tag, par);
`endif
  endtask

  task automatic idle_main(input string tag);
    check({tag, "_dout"}, dout, 1'b1);
    check({tag, "_vld"}, dout_valid, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_rdy"}, data_ready, 1'b1);
  endtask

  initial begin
    logic [7:0] s;

    // Reset state while rst is held.
    tick();
    tick();
    check("rst_dout", dout, 1'b1);
    check("rst_vld", dout_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rdy", data_ready, 1'b0);
    check("rst_g_rdy", g_data_ready, 1'b0);
    rst = 1'b0;
    #1;
    idle_main("rel");
    $display("reset released, idle state checked");

    // 0x55 MSB first.
    data_in = 8'h55; data_valid = 1'b1;
    check("w55_rdy0", data_ready, 1'b1);
    tick();
    data_valid = 1'b0;
    shift_main("w55", 8'b01010101, 1'b0);
    idle_main("w55_end");
    $display("word 55 serialized");

    // Back-to-back: 0xA5 then 0x3C with data_valid held high.
    data_in = 8'hA5; data_valid = 1'b1;
    check("b2b_rdy0", data_ready, 1'b1);
    tick();
    data_in = 8'h3C;
    shift_main("wA5", 8'b10100101, 1'b0);
    data_valid = 1'b0;
    shift_main("w3C", 8'b00111100, 1'b0);
    idle_main("b2b_end");
    $display("back-to-back A5/3C serialized");

    // GAP=2 instance with two queued words 0xC3, 0x81.
    g_data_in = 8'hC3; g_data_valid = 1'b1;
    check("gap_rdy0", g_data_ready, 1'b1);
    tick();
    g_data_in = 8'h81;
    s = 8'b11000011;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("gapC3_bit%0d", i), g_dout, s[7-i]);
      check($sformatf("gapC3_vld%0d", i), g_dout_valid, 1'b1);
      check($sformatf("gapC3_rdy%0d", i), g_data_ready, 1'b0);
      tick();
    end
`ifdef PISO_PARITY_EN
    check("gapC3_par", g_dout, 1'b0);
    check("gapC3_par_rdy", g_data_ready, 1'b0);
    tick();
`endif
    for (int i = 0; i < 2; i++) begin
      check($sformatf("gap_idle_dout%0d", i), g_dout, 1'b1);
      check($sformatf("gap_idle_vld%0d", i), g_dout_valid, 1'b0);
      check($sformatf("gap_idle_rdy%0d", i), g_data_ready, 1'b0);
      check($sformatf("gap_idle_busy%0d", i), g_busy, 1'b1);
      tick();
    end
    check("gap_back_idle_rdy", g_data_ready, 1'b1);
    check("gap_back_idle_busy", g_busy, 1'b0);
    check("gap_back_idle_vld", g_dout_valid, 1'b0);
    tick();
    g_data_valid = 1'b0;
    s = 8'b10000001;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("gap81_bit%0d", i), g_dout, s[7-i]);
      check($sformatf("gap81_vld%0d", i), g_dout_valid, 1'b1);
      tick();
    end
    $display("GAP=2 instance: C3 then 81 serialized with idle gap");

    // Reset pulsed at bit 4 of 0xF0.
    data_in = 8'hF0; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    s = 8'b11110000;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("wF0_bit%0d", i), dout, s[7-i]);
      if (i < 4) tick();
    end
    rst = 1'b1;
    #1;
    check("midrst_dout", dout, 1'b1);
    check("midrst_vld", dout_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_rdy", data_ready, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    idle_main("midrst_rel");
    data_in = 8'h80; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    shift_main("w80", 8'b10000000, 1'b1);
    idle_main("w80_end");
    $display("mid-frame reset recovered, word 80 serialized");

    // LSB-first: 0x01, with 0x06 offered during SHIFT.
    l_data_in = 8'h01; l_data_valid = 1'b1;
    check("lsb_rdy0", l_data_ready, 1'b1);
    tick();
    l_data_in = 8'h06;
    s = 8'b10000000;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("lsb01_bit%0d", i), l_dout, s[7-i]);
      check($sformatf("lsb01_vld%0d", i), l_dout_valid, 1'b1);
      check($sformatf("lsb01_rdy%0d", i), l_data_ready, (i == FRAME - 1));
      tick();
    end
`ifdef PISO_PARITY_EN
    check("lsb01_par", l_dout, 1'b1);
    check("lsb01_par_rdy", l_data_ready, 1'b1);
    tick();
`endif
    l_data_valid = 1'b0;
    s = 8'b01100000;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("lsb06_bit%0d", i), l_dout, s[7-i]);
      check($sformatf("lsb06_vld%0d", i), l_dout_valid, 1'b1);
      tick();
    end
`ifdef PISO_PARITY_EN
    check("lsb06_par", l_dout, 1'b0);
    tick();
`endif
    check("lsb_end_vld", l_dout_valid, 1'b0);
    check("lsb_end_dout", l_dout, 1'b1);
    check("lsb_end_rdy", l_data_ready, 1'b1);
    $display("LSB-first instance: 01 then 06 serialized");

    // Parity words 0x07 (odd count) and 0x03 (even count).
    data_in = 8'h07; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    shift_main("w07", 8'b00000111, 1'b1);
    idle_main("w07_end");
    data_in = 8'h03; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    shift_main("w03", 8'b00000011, 1'b0);
    idle_main("w03_end");
    $display("words 07 and 03 serialized");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Bound the run in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
